inst_fetch: RTL

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_pkg.sv | 43 ++++
 rtl/inst_fetch.sv | 96 +++++++++
 2 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared constants, FSM encoding and output payload for the instruction fetch stage.
package inst_fetch_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;

  localparam logic                   RST_ENABLE    = 1'b1;
  localparam logic [INST_W-1:0]      ZERO_WORD     = INST_W'(0);
  localparam logic [INST_ADDR_W-1:0] ZERO_ADDR     = INST_ADDR_W'(0);
  localparam logic [INST_ADDR_W-1:0] PC_STEP       = INST_ADDR_W'(4);
  localparam logic [INST_ADDR_W-1:0] PC_ALIGN_MASK = ~INST_ADDR_W'(3);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  // Payload presented to the IF/ID register.
  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
    logic                   valid;
  } if_out_t;

  function automatic logic [INST_ADDR_W-1:0] pc_align(input logic [INST_ADDR_W-1:0] addr);
    return addr & PC_ALIGN_MASK;
  endfunction

  // Wraps naturally at 32 bits: 0xFFFFFFFC -> 0x00000000.
  function automatic logic [INST_ADDR_W-1:0] pc_next(input logic [INST_ADDR_W-1:0] addr);
    return addr + PC_STEP;
  endfunction

  function automatic if_out_t make_bubble(input logic [INST_ADDR_W-1:0] pc);
    if_out_t b;
    b.pc    = pc;
    b.inst  = ZERO_WORD;
    b.valid = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch: walks the PC through the instruction ROM with a ready handshake,
// honours downstream stall and ID-stage branch redirects.
module inst_fetch
  import inst_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic        rom_ready_i,
  input  logic [31:0] rom_data_i,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  fetch_state_e           state_q, state_d;
  logic [INST_ADDR_W-1:0] pc_q, pc_d;
  if_out_t                out_q, out_d;
  logic                   rom_ce_q, rom_ce_d;

  // State, PC and presented-instruction registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q  <= ST_IDLE;
      pc_q     <= ZERO_ADDR;
      out_q    <= make_bubble(ZERO_ADDR);
      rom_ce_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      out_q    <= out_d;
      rom_ce_q <= rom_ce_d;
    end
  end

  // Next-state and datapath: branch beats stall, stall beats capture.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    out_d   = out_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end

      ST_REQ: begin
        if (branch_flag_i) begin
          pc_d    = pc_align(branch_target_i);
          out_d   = make_bubble(out_q.pc);
          state_d = ST_REQ;
        end else if (stall && out_q.valid) begin
          // Downstream still owns the presented instruction; drop this response.
          state_d = ST_HOLD;
        end else if (rom_ready_i) begin
          out_d.pc    = pc_q;
          out_d.inst  = rom_data_i;
          out_d.valid = 1'b1;
          pc_d        = pc_next(pc_q);
          state_d     = stall ? ST_HOLD : ST_REQ;
        end else if (!stall) begin
          out_d = make_bubble(out_q.pc);
        end
      end

      ST_HOLD: begin
        if (branch_flag_i) begin
          pc_d    = pc_align(branch_target_i);
          out_d   = make_bubble(out_q.pc);
          state_d = ST_REQ;
        end else if (!stall) begin
          // The held instruction is consumed on this edge.
          out_d   = make_bubble(out_q.pc);
          state_d = ST_REQ;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rom_ce_d = (state_d == ST_REQ);
  end

  assign rom_ce_o   = rom_ce_q;
  assign rom_addr_o = pc_q;
  assign if_pc      = out_q.pc;
  assign if_inst    = out_q.inst;
  assign if_valid   = out_q.valid;

endmodule
